fp_add_normalize: RTL and testbench
===================================

Name: fp_add_normalize

Overview:
- Add/normalize stage of the single-precision adder. Sits directly downstream of the mantissa-alignment stage.
- Consumes the two 33-bit aligned operands, each {sign, exp[7:0], mant[23:0]} with the hidden bit explicit.
- Adds or subtracts the mantissas, then normalizes iteratively, one bit position per cycle.
- Emits a packed 32-bit IEEE 754 result over a valid/ready handshake.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (the datapath mantissa is MAN_W+1 bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
op_a  input  33  aligned larger operand {sign, exp, 1.mant}
op_b  input  33  aligned smaller operand {sign, exp, shifted mant}; its exp field is ignored
in_valid  input  1  operands valid
in_ready  output  1  stage can accept
out_data  output  32  IEEE 754 result {sign, exp, frac}
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
overflow  output  1  result saturated to infinity; qualified by out_valid
underflow  output  1  result flushed to zero by exponent exhaustion; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE
  - out_valid=0, out_data=0, overflow=0, underflow=0
  - all internal registers 0
  - in_ready=0 while rst is high.
- Reset mid-operation: aborts the operation immediately. No output is produced for the aborted operands.
- FSM states: IDLE, ADD, NORM, DONE.
- in_ready = (state==IDLE) && !rst.
- IDLE:
  - On in_valid && in_ready at edge E0, register op_a, op_b, and exp=op_a[31:24].
  - Go to ADD.
- ADD (edge E1), using a 25-bit sum register:
  - Same signs: sum = ma + mb, sign = sa.
  - If sum[24]=1: sum = sum>>1 (truncate), exp = exp+1. If the new exp == 8'hFF, set overflow.
  - Different signs:
    - ma >= mb: sum = ma - mb, sign = sa.
    - Otherwise: sum = mb - ma, sign = sb.
  - Go to NORM.
- NORM, evaluated each edge, in priority order:
  - overflow set: result = {sign, 8'hFF, 23'b0} → DONE.
  - sum==0: result = +0 (32'h0), underflow=0 → DONE.
  - sum[23]=1: result = {sign, exp, sum[22:0]} → DONE.
  - exp==1: result = {sign, 31'b0}, underflow=1 → DONE.
  - Otherwise: sum = sum<<1, exp = exp-1, stay in NORM.
- Latency: with k normalization shifts, out_valid rises after edge E(2+k), k ∈ 0..23.
- DONE:
  - out_valid=1. out_data, overflow and underflow are held stable until out_valid && out_ready.
  - On that handshake edge: out_valid=0, go to IDLE.
  - in_ready is first high the cycle after the handshake. There is no input/output overlap; one operation is in flight at a time.
- Rounding: truncation only. Bits shifted out are discarded.
- Not supported: denormal, NaN and infinity inputs. Both hidden bits are taken from the inputs as given.
- Inputs are sampled only at the accept edge. Changes on op_a/op_b afterwards have no effect.
- in_valid while busy is ignored. The upstream stage holds its data until in_ready.

Test Plan:
1. Subtract, no shift: op_a={0,131,0xD00000} (26.0), op_b={1,131,0x340000} (-6.5 aligned) → out_data=0x419C0000 (19.5), out_valid after E2.
2. Add with carry: op_a={0,127,0xC00000}, op_b={0,127,0xC00000} → 0x40400000 (3.0), overflow=0.
3. Normalization shifts: op_a={0,127,0xC00000}, op_b={1,127,0xA00000} → 0x3E800000 (0.25), out_valid after E4 (k=2). Swapped magnitudes, op_a={0,127,0xA00000}, op_b={1,127,0xC00000} → 0xBE800000.
4. Cancellation and overflow:
   - op_a={0,127,0x800000}, op_b={1,127,0x800000} → 0x00000000, underflow=0.
   - op_a={0,254,0xFFFFFF}, op_b={0,254,0xFFFFFF} → 0x7F800000, overflow=1.
5. Underflow: op_a={0,2,0xC00000}, op_b={1,2,0xA00000} → 0x00000000, underflow=1.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0; the result is consumed when out_ready rises.
   - Pulse rst during NORM → out_valid=0 immediately; in_ready=1 the first cycle after rst deasserts; the next operation completes correctly.

Source files
------------

// File: rtl/fp_add_normalize.sv
// Add/normalize stage of the single-precision adder: adds or subtracts aligned
// mantissas, normalizes one bit per cycle, and emits a truncated IEEE 754 result.
module fp_add_normalize #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W+1:0]   op_a,
  input  logic [EXP_W+MAN_W+1:0]   op_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               o_dbg_state
);

  localparam int MW = MAN_W + 1;
  localparam int IW = EXP_W + MAN_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a producer keeps valid and data stable until that edge.

  logic [1:0]          r_state;
  logic                r_sa;
  logic                r_sb;
  logic [MW-1:0]       r_ma;
  logic [MW-1:0]       r_mb;
  logic [EXP_W-1:0]    r_exp;
  logic                r_sign;
  logic [MW:0]         r_sum;
  logic                r_ovf;
  logic [EXP_W+MAN_W:0] r_out_data;
  logic                r_out_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic [MW:0]         w_add;
  logic                w_same;
  logic                w_a_ge;
  logic [EXP_W-1:0]    w_exp_inc;

  always_comb begin
    w_add     = {1'b0, r_ma} + {1'b0, r_mb};
    w_same    = (r_sa == r_sb);
    w_a_ge    = (r_ma >= r_mb);
    w_exp_inc = r_exp + 1'b1;
  end

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sa    <= op_a[IW-1];
            r_sb    <= op_b[IW-1];
            r_ma    <= op_a[MW-1:0];
            r_mb    <= op_b[MW-1:0];
            r_exp   <= op_a[IW-2 -: EXP_W];
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_ovf <= 1'b0;
          if (w_same) begin
            r_sign <= r_sa;
            // Carry out of the hidden bit: renormalize right, dropping the LSB.
            if (w_add[MW]) begin
              r_sum <= w_add >> 1;
              r_exp <= w_exp_inc;
              r_ovf <= (w_exp_inc == {EXP_W{1'b1}});
            end else begin
              r_sum <= w_add;
            end
          end else if (w_a_ge) begin
            r_sign <= r_sa;
            r_sum  <= {1'b0, r_ma - r_mb};
          end else begin
            r_sign <= r_sb;
            r_sum  <= {1'b0, r_mb - r_ma};
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_ovf) begin
            r_out_data  <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_overflow  <= 1'b1;
            r_underflow <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_sum == '0) begin
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_sum[MAN_W]) begin
            r_out_data  <= {r_sign, r_exp, r_sum[MAN_W-1:0]};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_exp == EXP_W'(1)) begin
            // Exponent exhausted before the leading one reached the hidden bit.
            r_out_data  <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Bench for fp_add_normalize: directed plan cases plus randomized operands,
// scored against an arithmetic reference model of the add/normalize rules.
module tb_fp_add_normalize;

  logic        clk;
  logic        rst;
  logic [32:0] op_a;
  logic [32:0] op_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        underflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fp_add_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .underflow(underflow), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] mk(input logic s, input logic [7:0] e, input logic [23:0] m);
    return {s, e, m};
  endfunction

  // Reference: signed-magnitude sum, then place the leading one at bit 23.
  function automatic void ref_model(input logic [32:0] a, input logic [32:0] b,
                                    output logic [31:0] d, output logic ov,
                                    output logic un, output int k);
    int s, e, p, need;
    logic neg;
    logic [24:0] mag;
    s = (a[32] ? -int'(a[23:0]) : int'(a[23:0])) + (b[32] ? -int'(b[23:0]) : int'(b[23:0]));
    neg = (s < 0);
    mag = 25'(neg ? -s : s);
    e = int'(a[31:24]);
    ov = 1'b0; un = 1'b0; k = 0; d = '0;
    if (mag == 0) return;
    if (mag >= 25'h1000000) begin
      mag = mag >> 1;
      e = e + 1;
      if (e == 255) begin
        d = {neg, 8'hFF, 23'h0};
        ov = 1'b1;
        return;
      end
    end
    p = 0;
    for (int i = 24; i >= 0; i--) if (mag[i]) begin p = i; break; end
    need = 23 - p;
    if (need > e - 1) begin
      un = 1'b1;
      k = e - 1;
      d = {neg, 31'h0};
    end else begin
      k = need;
      e = e - need;
      mag = mag << need;
      d = {neg, 8'(e), mag[22:0]};
    end
  endfunction

  // driver: accept one operation, check latency/result, hold, then consume
  task automatic run_op(input logic [32:0] a, input logic [32:0] b, input int hold,
                        input logic use_fix, input logic [31:0] fix_d);
    logic [31:0] md, expd;
    logic mov, mun;
    int mk_k, lat;
    ref_model(a, b, md, mov, mun, mk_k);
    exp_q.push_back(use_fix ? fix_d : md);
    @(negedge clk);
    op_a = a; op_b = b; in_valid = 1'b1;
    for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = {$urandom(), 1'b0}; op_b = {$urandom(), 1'b1};
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin lat = n; break; end
    end
    chk("latency", 32'(lat), 32'(2 + mk_k));
    expd = exp_q.pop_front();
    chk("out_data", out_data, expd);
    chk("overflow", 32'(overflow), 32'(mov));
    chk("underflow", 32'(underflow), 32'(mun));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, expd);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [32:0] ra, rb;
    logic [23:0] ma;
    int e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(mk(0, 131, 24'hD00000), mk(1, 131, 24'h340000), 0, 1, 32'h419C0000);
    run_op(mk(0, 127, 24'hC00000), mk(0, 127, 24'hC00000), 0, 1, 32'h40400000);
    run_op(mk(0, 127, 24'hC00000), mk(1, 127, 24'hA00000), 0, 1, 32'h3E800000);
    run_op(mk(0, 127, 24'hA00000), mk(1, 127, 24'hC00000), 0, 1, 32'hBE800000);
    run_op(mk(0, 127, 24'h800000), mk(1, 127, 24'h800000), 0, 1, 32'h00000000);
    run_op(mk(0, 254, 24'hFFFFFF), mk(0, 254, 24'hFFFFFF), 0, 1, 32'h7F800000);
    run_op(mk(0, 2, 24'hC00000), mk(1, 2, 24'hA00000), 0, 1, 32'h00000000);
    run_op(mk(1, 100, 24'h900000), mk(1, 100, 24'h100000), 5, 1, 32'hB2200000);

    // reset pulse while normalizing a deep cancellation
    @(negedge clk);
    op_a = mk(0, 100, 24'h800001); op_b = mk(1, 100, 24'h800000); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_norm_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("no_aborted_output", 32'(out_valid), 32'd0);
    end
    run_op(mk(0, 131, 24'hD00000), mk(1, 131, 24'h340000), 0, 1, 32'h419C0000);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: e = $urandom_range(1, 8);
        1: e = $urandom_range(248, 254);
        default: e = $urandom_range(1, 254);
      endcase
      ma = {1'b1, 23'($urandom())};
      ra = mk(1'($urandom()), 8'(e), ma);
      if ($urandom_range(0, 3) == 0)
        rb = mk(~ra[32], 8'(e), ma - 24'($urandom_range(0, 15)));
      else
        rb = mk(1'($urandom()), 8'($urandom()), {1'b1, 23'($urandom())} >> $urandom_range(0, 24));
      run_op(ra, rb, $urandom_range(0, 3), 0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
